sys_rst_seq: RTL and testbench



---
 rtl/sys_rst_seq.sv | 97 +++++++++
 tb/tb_sys_rst_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sys_rst_seq.sv
// sys_rst_seq: board reset sequencer that synchronizes and debounces the reset/wake buttons,
// qualifies MMCM lock, then releases AON, core and peripheral resets in order.
module sys_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int LOCK_HOLD       = 256,
  parameter int AON_TO_CORE     = 64,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fpga_rst_raw,
  input  logic       mcu_rst_raw,
  input  logic       wakeup_raw,
  input  logic       mmcm_locked,
  output logic       aon_erst_n,
  output logic       core_rst_n,
  output logic       periph_rst,
  output logic       wakeup_n_clean,
  output logic       rst_evt,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_LOCK = 3'd1,
    S_AON  = 3'd2,
    S_CORE = 3'd3,
    S_RUN  = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] AON_LAST  = CNT_W'(AON_TO_CORE - 1);
  // bit order: lock, wakeup, mcu, fpga; idle levels are what each flop resets to
  localparam logic [3:0] IDLE = 4'b1011;
  logic [3:0] raw, sync_s;
  logic [2:0] stable;
  logic btn_ok, lock_s, ok;
  state_t state_q, nxt;
  logic [CNT_W-1:0] seq_q, seq_nxt;
  assign raw = {mmcm_locked, wakeup_raw, mcu_rst_raw, fpga_rst_raw};
  for (genvar i = 0; i < 4; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] q;
    always_ff @(posedge clk)
      if (!rst_n) q <= {SYNC_STAGES{IDLE[i]}};
      else q <= {q[SYNC_STAGES-2:0], raw[i]};
    assign sync_s[i] = q[SYNC_STAGES-1];
  end
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic st;
    always_ff @(posedge clk)
      if (!rst_n) begin
        cnt <= '0;
        st  <= IDLE[i];
      end else if (sync_s[i] == st) cnt <= '0;
      else if (cnt >= DEB_LAST) begin
        st  <= sync_s[i];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign stable[i] = st;
  end
  assign btn_ok = stable[0] & stable[1];
  assign lock_s = sync_s[3];
  assign ok     = btn_ok & lock_s;
  // losing buttons or lock always wins over a counter completing in the same cycle
  always_comb begin
    nxt = S_HOLD;
    case (state_q)
      S_HOLD:  nxt = ok ? S_LOCK : S_HOLD;
      S_LOCK:  nxt = !ok ? S_HOLD : (seq_q == LOCK_LAST ? S_AON : S_LOCK);
      S_AON:   nxt = !ok ? S_HOLD : (seq_q == AON_LAST ? S_CORE : S_AON);
      S_CORE:  nxt = ok ? S_RUN : S_HOLD;
      S_RUN:   nxt = ok ? S_RUN : S_HOLD;
      default: nxt = S_HOLD;
    endcase
    seq_nxt = (nxt != state_q || nxt == S_HOLD) ? '0 : seq_q + {{(CNT_W-1){1'b0}}, seq_q != '1};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q        <= S_HOLD;
      seq_q          <= '0;
      aon_erst_n     <= 1'b0;
      core_rst_n     <= 1'b0;
      periph_rst     <= 1'b1;
      wakeup_n_clean <= 1'b1;
      rst_evt        <= 1'b0;
    end else begin
      state_q        <= nxt;
      seq_q          <= seq_nxt;
      aon_erst_n     <= nxt inside {S_AON, S_CORE, S_RUN};
      core_rst_n     <= nxt inside {S_CORE, S_RUN};
      periph_rst     <= nxt != S_RUN;
      wakeup_n_clean <= ~stable[2];
      rst_evt        <= nxt == S_HOLD && state_q != S_HOLD;
    end
  assign state_o = state_q;
endmodule

// File: tb/tb_sys_rst_seq.sv
// tb_sys_rst_seq: directed table plus hand-timed corner sequences for the reset sequencer.
module tb_sys_rst_seq;
  logic clk = 1'b0;
  logic rst_n, fpga_rst_raw, mcu_rst_raw, wakeup_raw, mmcm_locked;
  logic aon_erst_n, core_rst_n, periph_rst, wakeup_n_clean, rst_evt;
  logic [2:0] state_o;
  int checks = 0, errors = 0, evt_cnt = 0;
  typedef struct packed {
    logic rst_n, fpga, mcu, wake, lock;
    logic [2:0] st;
    logic aon, core, periph, wn, evt;
  } vec_t;
  vec_t tbl [18];
  sys_rst_seq #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LOCK_HOLD(8), .AON_TO_CORE(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fpga_rst_raw(fpga_rst_raw), .mcu_rst_raw(mcu_rst_raw),
    .wakeup_raw(wakeup_raw), .mmcm_locked(mmcm_locked), .aon_erst_n(aon_erst_n),
    .core_rst_n(core_rst_n), .periph_rst(periph_rst), .wakeup_n_clean(wakeup_n_clean),
    .rst_evt(rst_evt), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst_evt) evt_cnt++;
  endtask
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {state_o, aon_erst_n, core_rst_n, periph_rst, wakeup_n_clean, rst_evt};
  endfunction
  task automatic wait_state(input string name, input logic [2:0] s, input int budget);
    for (int k = 0; k < budget; k++) begin
      cyc();
      if (state_o == s) break;
    end
    check(name, 16'(state_o), 16'(s));
  endtask
  initial begin
    for (int i = 0; i < 18; i++)
      tbl[i] = i < 3  ? {5'b01101, 3'd0, 5'b00110} :
               i < 11 ? {5'b11101, 3'd1, 5'b00110} :
               i < 15 ? {5'b11101, 3'd2, 5'b10110} :
               i < 16 ? {5'b11101, 3'd3, 5'b11110} :
                        {5'b11101, 3'd4, 5'b11010};
    for (int i = 0; i < 18; i++) begin
      {rst_n, fpga_rst_raw, mcu_rst_raw, wakeup_raw, mmcm_locked} =
        {tbl[i].rst_n, tbl[i].fpga, tbl[i].mcu, tbl[i].wake, tbl[i].lock};
      cyc();
      check($sformatf("seq row %0d", i), 16'(outs()),
            16'({tbl[i].st, tbl[i].aon, tbl[i].core, tbl[i].periph, tbl[i].wn, tbl[i].evt}));
    end
    // short mcu glitch must be filtered out
    evt_cnt = 0;
    mcu_rst_raw = 1'b0;
    repeat (3) cyc();
    mcu_rst_raw = 1'b1;
    repeat (10) cyc();
    check("glitch state", 16'(state_o), 16'd4);
    check("glitch evt", 16'(evt_cnt), 16'd0);
    // 6-cycle press aborts to hold after sync+debounce+1 edges
    mcu_rst_raw = 1'b0;
    repeat (6) cyc();
    check("press edge6 state", 16'(state_o), 16'd4);
    mcu_rst_raw = 1'b1;
    cyc();
    check("press edge7 outs", 16'(outs()), 16'({3'd0, 5'b00111}));
    cyc();
    check("press evt drop", 16'(rst_evt), 16'd0);
    wait_state("press restart run", 3'd4, 60);
    check("press evt count", 16'(evt_cnt), 16'd1);
    // lock loss in S_AON
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("aon lock entry", 16'(state_o), 16'd1);
    repeat (8) cyc();
    check("aon reached", 16'({state_o, aon_erst_n}), 16'({3'd2, 1'b1}));
    mmcm_locked = 1'b0;
    repeat (2) cyc();
    check("aon lockloss +2", 16'(state_o), 16'd2);
    cyc();
    check("aon lockloss +3", 16'(outs()), 16'({3'd0, 5'b00111}));
    mmcm_locked = 1'b1;
    repeat (2) cyc();
    check("relock hold", 16'(state_o), 16'd0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      check($sformatf("relock lock %0d", k), 16'(state_o), 16'd1);
    end
    cyc();
    check("relock aon", 16'(state_o), 16'd2);
    // lock lost exactly as the lock counter reaches its last value
    rst_n = 1'b0;
    cyc();
    check("rst from aon", 16'(outs()), 16'({3'd0, 5'b00110}));
    rst_n = 1'b1;
    cyc();
    repeat (5) cyc();
    mmcm_locked = 1'b0;
    cyc();
    check("race e6", 16'(state_o), 16'd1);
    cyc();
    check("race e7", 16'(state_o), 16'd1);
    cyc();
    check("race e8", 16'(outs()), 16'({3'd0, 5'b00111}));
    mmcm_locked = 1'b1;
    // wakeup debounce
    wakeup_raw = 1'b1;
    repeat (5) cyc();
    wakeup_raw = 1'b0;
    cyc();
    check("wake edge6", 16'(wakeup_n_clean), 16'd1);
    cyc();
    check("wake edge7", 16'(wakeup_n_clean), 16'd0);
    for (int k = 0; k < 20 && !wakeup_n_clean; k++) cyc();
    check("wake release", 16'(wakeup_n_clean), 16'd1);
    wakeup_raw = 1'b1;
    repeat (2) cyc();
    wakeup_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check($sformatf("wake short %0d", k), 16'(wakeup_n_clean), 16'd1);
    end
    // one-cycle rst_n while running
    wait_state("run before rst", 3'd4, 60);
    rst_n = 1'b0;
    cyc();
    check("rst in run", 16'(outs()), 16'({3'd0, 5'b00110}));
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
